// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the WB stage and a queued long-latency unit.
// WB has priority; starved LU results are drained by a one-cycle WB hold, and stale LU results are squashed.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] RdW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              HoldW,
  output logic              RegWriteRF,
  output logic [ADDR_W-1:0] RdRF,
  output logic [DATA_W-1:0] DataRF
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int SW    = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PTR_W-1:0]   rptr_q, wptr_q;
  logic [DEPTH-1:0]   live_q, live_d;
  logic [ADDR_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];

  logic wb_req, full, nonempty, head_live;
  logic wb_own, head_wr, pop, push, pop_live, any_live_d;

  always_comb begin
    wb_req    = RegWriteW & (|RdW);
    full      = (count_q == CW'(DEPTH));
    nonempty  = (count_q != '0);
    head_live = nonempty & live_q[rptr_q];
    wb_own    = 1'b0;
    head_wr   = 1'b0;
    pop       = 1'b0;
    HoldW     = 1'b0;

    // Port owner: forced drain, then WB, then live head; a dead head pops without the port.
    if (state_q == FORCE) begin
      HoldW   = rst;
      head_wr = head_live;
      pop     = nonempty;
    end else if (wb_req) begin
      wb_own = 1'b1;
      pop    = nonempty & ~head_live;
    end else if (head_live) begin
      head_wr = 1'b1;
      pop     = 1'b1;
    end else begin
      pop = nonempty;
    end

    push       = lu_valid & ~full & (|lu_rd);
    lu_ready   = rst & ~full;
    RegWriteRF = rst & (wb_own | head_wr);
    RdRF       = '0;
    DataRF     = '0;
    if (rst && wb_own) begin
      RdRF   = RdW;
      DataRF = ResultW;
    end else if (rst && head_wr) begin
      RdRF   = rd_q[rptr_q];
      DataRF = data_q[rptr_q];
    end

    // WAW squash covers queued entries and the entry pushed this cycle.
    live_d = live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wb_own && rd_q[i] == RdW) live_d[i] = 1'b0;
    end
    if (pop)  live_d[rptr_q] = 1'b0;
    if (push) live_d[wptr_q] = ~(wb_own & (lu_rd == RdW));
    any_live_d = |live_d;
    pop_live   = pop & head_live;
    count_d    = count_q + CW'(push) - CW'(pop);

    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: state_d = any_live_d ? PEND : IDLE;
      PEND: begin
        if (pop_live)                         cnt_d = '0;
        else if (wb_own && cnt_q != SW'(STARVE_MAX)) cnt_d = cnt_q + SW'(1);
        else                                  cnt_d = cnt_q;
        if (!any_live_d) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_d == SW'(STARVE_MAX)) begin
          state_d = FORCE;
        end
      end
      FORCE:   state_d = any_live_d ? PEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      live_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      live_q  <= live_d;
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
      if (push) begin
        wptr_q         <= wptr_q + PTR_W'(1);
        rd_q[wptr_q]   <= lu_rd;
        data_q[wptr_q] <= lu_data;
      end
    end
  end

endmodule
